icsp_shift_engine: RTL and testbench
====================================

// Module: icsp_shift_engine
// PURPOSE
//   Parametrised ICSP serial engine for PIC24-class targets. It generalises the fixed pic24programmer.
//   It runs queued-style commands (SIX, REGOUT, RAW key, MCLR control) through a valid/ready port.
//   It generates PGC/PGD/MCLR timing at a programmable rate and returns REGOUT read data with a strobe.
//   Sits between the programming sequencer FSM and the target pin drivers (PGD tristate is external).
// PARAMETERS
//   CLK_DIV    4   clk cycles per PGC half-period (>=1); one bit period = 2*CLK_DIV cycles
//   PAYLOAD_W  24  SIX payload bits, shifted LSB first
//   READ_W     16  REGOUT read bits, sampled LSB first
//   IDLE_CLKS  8   PGC clocks between REGOUT opcode and read phase
//   KEY_W      32  RAW shift length, MSB first (entry key); cmd_data width
// PORTS
//   clk        in   1          system clock
//   rst        in   1          asynchronous reset, active-high
//   cmd_valid  in   1          command present
//   cmd_ready  out  1          engine idle and able to accept
//   cmd_op     in   2          0=SIX 1=REGOUT 2=RAW 3=SET_MCLR
//   cmd_data   in   KEY_W      SIX: [PAYLOAD_W-1:0]; RAW: all; SET_MCLR: bit0 = MCLRn level
//   PGCx       out  1          ICSP clock
//   PGDx_in    in   1          ICSP data from target
//   PGDx_out   out  1          ICSP data to target
//   PGDx_dir   out  1          1 = FPGA drives PGD, 0 = PGD input
//   MCLRn      out  1          target reset, active-low
//   dvalid     out  1          one-cycle strobe: dout valid
//   dout       out  READ_W     last REGOUT result
//   busy       out  1          ~cmd_ready
// BEHAVIOUR
//   Reset values: PGCx=0, PGDx_out=0, PGDx_dir=0, MCLRn=0, dvalid=0, dout=0, cmd_ready=0.
//   cmd_ready rises 1 cycle after rst deasserts. FSM is in IDLE then.
//   Accept on cmd_valid&cmd_ready. cmd_ready drops the next cycle. cmd_valid while busy is ignored.
//   FSM: IDLE -> OPC -> {PAYLOAD | IDLEC -> TURN -> READ | RAWSH} -> DONE -> IDLE; SET_MCLR: IDLE->DONE.
//   Bit timing: the cycle after accept, PGDx_out presents bit 0 and PGC goes low for CLK_DIV cycles.
//     PGC then goes high for CLK_DIV cycles.
//     The target latches on the PGC falling edge. The next bit changes in the same cycle PGC falls.
//   OPC: 4-bit opcode, LSB first, PGDx_dir=1. SIX=4'b0000, REGOUT=4'b0001.
//   PAYLOAD (SIX): PAYLOAD_W bits of cmd_data, LSB first; total 4+PAYLOAD_W PGC pulses.
//   IDLEC (REGOUT): IDLE_CLKS PGC pulses, PGDx_out=0, PGDx_dir=1.
//   TURN: PGDx_dir=0 for one full bit period. No PGC pulse.
//   READ: READ_W PGC pulses. PGDx_in is sampled in the last clk cycle of each PGC high phase.
//     Sampled bits are shifted in LSB first.
//   RAWSH: KEY_W bits of cmd_data, MSB first, PGDx_dir=1.
//   SET_MCLR: MCLRn <= cmd_data[0] one cycle after accept. No PGC activity.
//   DONE: PGCx=0, PGDx_out=0, PGDx_dir=1 after SIX/RAW, PGDx_dir=0 after REGOUT. Lasts 1 cycle.
//     cmd_ready=1 the following cycle.
//     Back-to-back gap between the last PGC fall and the next first PGC low phase: 2 clk cycles.
//   REGOUT DONE: dout updated, and dvalid=1 for exactly that one cycle.
//     dout holds its value until the next REGOUT completes.
//   MCLRn changes only via SET_MCLR or rst. It is unaffected by other ops.
//   Bit and phase counters are sized for max(KEY_W, PAYLOAD_W, READ_W, IDLE_CLKS) and CLK_DIV.
//     They never wrap mid-command.
//   rst mid-command: all outputs return to reset values immediately (async). The partial command is dropped.
//     No dvalid pulse occurs.
// TESTING
//   CLK_DIV=2, SIX data 0x123456 -> 28 PGC pulses of period 4 clk.
//     PGD bits 0000 then 0x123456 LSB first. dvalid stays 0.
//   REGOUT with target model driving 0xA5C3 LSB first on PGC rise.
//     -> 4+8 output pulses, 1 quiet bit period with dir=0, 16 read pulses.
//     -> dout=0xA5C3, one-cycle dvalid.
//   RAW 0x4D434851 -> 32 pulses, PGD MSB first (0,1,0,0,1,1,0,1,...). dir=1 throughout.
//   SET_MCLR 1, then 0 -> MCLRn high then low one cycle after each accept. PGCx stays 0.
//   Back-to-back SIX, REGOUT with cmd_valid held.
//     -> second accepted the cycle cmd_ready rises. cmd_valid during busy is not accepted.
//   Assert rst during the 10th PAYLOAD bit -> PGCx, PGDx_dir, MCLRn = 0 immediately.
//     -> cmd_ready=1 one cycle after release. No dvalid.

Source files
------------

// File: rtl/icsp_shift_engine.sv
// ICSP serial engine for PIC24-class targets: runs SIX / REGOUT / RAW / SET_MCLR
// commands and produces PGC/PGD/MCLR waveforms at a CLK_DIV-derived bit rate.
module icsp_shift_engine #(
    parameter int CLK_DIV   = 4,
    parameter int PAYLOAD_W = 24,
    parameter int READ_W    = 16,
    parameter int IDLE_CLKS = 8,
    parameter int KEY_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [KEY_W-1:0]  cmd_data,
    output logic              PGCx,
    input  logic              PGDx_in,
    output logic              PGDx_out,
    output logic              PGDx_dir,
    output logic              MCLRn,
    output logic              dvalid,
    output logic [READ_W-1:0] dout,
    output logic              busy,
    output logic [2:0]        dbg_state
);
    // Handshake: a command is taken on any rising clk edge where cmd_valid and
    // cmd_ready are both high; cmd_ready stays low until the engine is idle again.

    localparam int MAX_A    = (KEY_W > PAYLOAD_W) ? KEY_W : PAYLOAD_W;
    localparam int MAX_B    = (READ_W > IDLE_CLKS) ? READ_W : IDLE_CLKS;
    localparam int MAX_C    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_BITS = (MAX_C > 4) ? MAX_C : 4;
    localparam int BW       = $clog2(MAX_BITS + 1);
    localparam int PW       = $clog2(CLK_DIV + 1);
    localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);

    localparam logic [1:0] OP_SIX    = 2'd0;
    localparam logic [1:0] OP_REGOUT = 2'd1;
    localparam logic [1:0] OP_RAW    = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE, S_OPC, S_PAYLOAD, S_IDLEC, S_TURN, S_READ, S_RAWSH, S_DONE
    } state_t;

    state_t              state;
    logic [1:0]          op_q;
    logic [3:0]          opc_sh;
    logic [KEY_W-1:0]    data_sh;
    logic [READ_W-1:0]   rd_sh;
    logic [BW-1:0]       bit_cnt;
    logic [PW-1:0]       ph_cnt;
    logic                hi;

    logic                accept;
    logic                ph_end;
    logic                seg_last;
    logic [3:0]          opc_next;
    logic [KEY_W-1:0]    data_shr;
    logic [KEY_W-1:0]    data_shl;
    logic [READ_W-1:0]   rd_next;

    assign accept    = (state == S_IDLE) && cmd_valid && cmd_ready;
    assign ph_end    = (ph_cnt == PH_LAST);
    assign opc_next  = opc_sh >> 1;
    assign data_shr  = data_sh >> 1;
    assign data_shl  = data_sh << 1;
    assign rd_next   = {PGDx_in, rd_sh[READ_W-1:1]};
    assign busy      = ~cmd_ready;
    assign dbg_state = state;

    // Last bit of the current segment; TURN is a single quiet bit period.
    always_comb begin
        seg_last = 1'b0;
        case (state)
            S_OPC:     seg_last = (bit_cnt == BW'(3));
            S_PAYLOAD: seg_last = (bit_cnt == BW'(PAYLOAD_W - 1));
            S_IDLEC:   seg_last = (bit_cnt == BW'(IDLE_CLKS - 1));
            S_TURN:    seg_last = 1'b1;
            S_READ:    seg_last = (bit_cnt == BW'(READ_W - 1));
            S_RAWSH:   seg_last = (bit_cnt == BW'(KEY_W - 1));
            default:   seg_last = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            op_q      <= '0;
            opc_sh    <= '0;
            data_sh   <= '0;
            rd_sh     <= '0;
            bit_cnt   <= '0;
            ph_cnt    <= '0;
            hi        <= 1'b0;
            cmd_ready <= 1'b0;
            PGCx      <= 1'b0;
            PGDx_out  <= 1'b0;
            PGDx_dir  <= 1'b0;
            MCLRn     <= 1'b0;
            dvalid    <= 1'b0;
            dout      <= '0;
        end else begin
            dvalid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        op_q      <= cmd_op;
                        data_sh   <= cmd_data;
                        bit_cnt   <= '0;
                        ph_cnt    <= '0;
                        hi        <= 1'b0;
                        PGCx      <= 1'b0;
                        case (cmd_op)
                            OP_SIX, OP_REGOUT: begin
                                opc_sh   <= {3'b000, cmd_op == OP_REGOUT};
                                PGDx_out <= (cmd_op == OP_REGOUT);
                                PGDx_dir <= 1'b1;
                                state    <= S_OPC;
                            end
                            OP_RAW: begin
                                PGDx_out <= cmd_data[KEY_W-1];
                                PGDx_dir <= 1'b1;
                                state    <= S_RAWSH;
                            end
                            default: begin
                                MCLRn <= cmd_data[0];
                                state <= S_DONE;
                            end
                        endcase
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end

                S_DONE: begin
                    state     <= S_IDLE;
                    cmd_ready <= 1'b1;
                end

                default: begin
                    if (!ph_end) begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end else begin
                        ph_cnt <= '0;
                        hi     <= ~hi;
                        if (!hi) begin
                            PGCx <= (state != S_TURN);
                        end else begin
                            // PGC falls here; the next bit is presented in the same cycle.
                            PGCx    <= 1'b0;
                            bit_cnt <= seg_last ? '0 : bit_cnt + 1'b1;
                            case (state)
                                S_OPC: begin
                                    if (seg_last) begin
                                        if (op_q == OP_SIX) begin
                                            state    <= S_PAYLOAD;
                                            PGDx_out <= data_sh[0];
                                        end else begin
                                            state    <= S_IDLEC;
                                            PGDx_out <= 1'b0;
                                        end
                                    end else begin
                                        opc_sh   <= opc_next;
                                        PGDx_out <= opc_next[0];
                                    end
                                end
                                S_PAYLOAD: begin
                                    if (seg_last) begin
                                        state    <= S_DONE;
                                        PGDx_out <= 1'b0;
                                        PGDx_dir <= 1'b1;
                                    end else begin
                                        data_sh  <= data_shr;
                                        PGDx_out <= data_shr[0];
                                    end
                                end
                                S_IDLEC: begin
                                    if (seg_last) begin
                                        state    <= S_TURN;
                                        PGDx_dir <= 1'b0;
                                    end
                                end
                                S_TURN: begin
                                    state <= S_READ;
                                end
                                S_READ: begin
                                    rd_sh <= rd_next;
                                    if (seg_last) begin
                                        state    <= S_DONE;
                                        dout     <= rd_next;
                                        dvalid   <= 1'b1;
                                        PGDx_out <= 1'b0;
                                        PGDx_dir <= 1'b0;
                                    end
                                end
                                S_RAWSH: begin
                                    if (seg_last) begin
                                        state    <= S_DONE;
                                        PGDx_out <= 1'b0;
                                        PGDx_dir <= 1'b1;
                                    end else begin
                                        data_sh  <= data_shl;
                                        PGDx_out <= data_shl[KEY_W-1];
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icsp_shift_engine.sv
// Bench for icsp_shift_engine: drives commands, models the ICSP target and
// checks the pin waveforms against bit lists built from the command rules.
module tb_icsp_shift_engine;
    localparam int CD = 2;
    localparam int PW = 24;
    localparam int RW = 16;
    localparam int IC = 8;
    localparam int KW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic [1:0]    cmd_op = 2'd0;
    logic [KW-1:0] cmd_data = '0;
    logic          PGDx_in = 1'b0;
    logic          cmd_ready;
    logic          PGCx;
    logic          PGDx_out;
    logic          PGDx_dir;
    logic          MCLRn;
    logic          dvalid;
    logic [RW-1:0] dout;
    logic          busy;
    logic [2:0]    dbg_state;

    icsp_shift_engine #(
        .CLK_DIV(CD), .PAYLOAD_W(PW), .READ_W(RW), .IDLE_CLKS(IC), .KEY_W(KW)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .PGCx(PGCx), .PGDx_in(PGDx_in),
        .PGDx_out(PGDx_out), .PGDx_dir(PGDx_dir), .MCLRn(MCLRn), .dvalid(dvalid),
        .dout(dout), .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Pin monitor and target model state
    int            ncyc = 0;
    int            rise_c[$];
    logic [63:0]   obs_bits = '0;
    logic [63:0]   obs_dirs = '0;
    int            n_fall = 0;
    int            dv_cnt = 0;
    logic [RW-1:0] dv_val = '0;
    int            mclr_chg = 0;
    logic          pgc_prev = 1'b0;
    logic          out_prev = 1'b0;
    logic          dir_prev = 1'b0;
    logic          mclr_prev = 1'b0;
    logic [RW-1:0] tgt_word = '0;
    int            tgt_idx = 0;
    int            acc_c = 0;

    logic [0:0]    exp_q[$];

    always @(negedge clk) begin
        ncyc++;
        if (PGCx === 1'b1 && pgc_prev === 1'b0) begin
            rise_c.push_back(ncyc);
            // Target puts the next read bit on PGD at each PGC rise while it owns the line.
            if (PGDx_dir === 1'b0 && tgt_idx < RW) begin
                PGDx_in = tgt_word[tgt_idx];
                tgt_idx++;
            end
        end
        if (PGCx === 1'b0 && pgc_prev === 1'b1) begin
            if (n_fall < 64) begin
                obs_bits[n_fall] = out_prev;
                obs_dirs[n_fall] = dir_prev;
            end
            n_fall++;
        end
        if (dvalid === 1'b1) begin
            dv_cnt++;
            dv_val = dout;
        end
        if (MCLRn !== mclr_prev) mclr_chg++;
        pgc_prev  = PGCx;
        out_prev  = PGDx_out;
        dir_prev  = PGDx_dir;
        mclr_prev = MCLRn;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] pack_exp();
        logic [63:0] v = '0;
        for (int i = 0; i < exp_q.size() && i < 64; i++) v[i] = exp_q[i][0];
        return v;
    endfunction

    function automatic logic [63:0] ones(input int n);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic clear_mon();
        rise_c.delete();
        obs_bits = '0;
        obs_dirs = '0;
        n_fall   = 0;
        dv_cnt   = 0;
        mclr_chg = 0;
        tgt_idx  = 0;
        PGDx_in  = 1'b0;
    endtask

    task automatic send(input logic [1:0] op, input logic [KW-1:0] data, input bit hold);
        int n = 0;
        cmd_op    = op;
        cmd_data  = data;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && n < 2000) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout: cmd_ready=%b required 1", cmd_ready);
        end
        acc_c = ncyc;
        @(negedge clk); #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 2000) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_timeout: cmd_ready=%b required 1", cmd_ready);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({PGCx, PGDx_out, PGDx_dir, MCLRn, dvalid, cmd_ready, busy} !== 7'b0000001 || dout !== '0) begin
            errors++;
            $display("FAIL reset_values: pins=%b dout=%h required 0000001 / 0",
                     {PGCx, PGDx_out, PGDx_dir, MCLRn, dvalid, cmd_ready, busy}, dout);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_early: cmd_ready=%b required 0", cmd_ready);
        end
        @(negedge clk); #1;
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_rise: cmd_ready=%b busy=%b required 1 0", cmd_ready, busy);
        end
    endtask

    task automatic test_six(input logic [KW-1:0] data);
        logic [63:0] expv;
        int bad_gap = 0;
        int lat;
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(1'b0);
        for (int i = 0; i < PW; i++) exp_q.push_back(data[i]);
        expv = pack_exp();
        clear_mon();
        send(2'd0, data, 1'b0);
        wait_idle();
        lat = (rise_c.size() > 0) ? rise_c[0] - acc_c : -1;
        for (int i = 1; i < rise_c.size(); i++) if (rise_c[i] - rise_c[i-1] != 2 * CD) bad_gap++;
        checks++;
        if (n_fall != 4 + PW) begin
            errors++;
            $display("FAIL six_pulses: got %0d required %0d", n_fall, 4 + PW);
        end
        checks++;
        if (obs_bits !== expv) begin
            errors++;
            $display("FAIL six_bits: got %h required %h", obs_bits, expv);
        end
        checks++;
        if (obs_dirs !== ones(4 + PW)) begin
            errors++;
            $display("FAIL six_dir: got %h required %h", obs_dirs, ones(4 + PW));
        end
        checks++;
        if (lat != CD + 1 || bad_gap != 0) begin
            errors++;
            $display("FAIL six_timing: first_rise=%0d bad_periods=%0d required %0d 0", lat, bad_gap, CD + 1);
        end
        checks++;
        if (dv_cnt != 0 || mclr_chg != 0) begin
            errors++;
            $display("FAIL six_side: dvalid=%0d mclr_changes=%0d required 0 0", dv_cnt, mclr_chg);
        end
        checks++;
        if ({PGCx, PGDx_out, PGDx_dir} !== 3'b001) begin
            errors++;
            $display("FAIL six_done_pins: got %b required 001", {PGCx, PGDx_out, PGDx_dir});
        end
    endtask

    task automatic test_regout(input logic [RW-1:0] word);
        logic [63:0] expv;
        int bad_gap = 0;
        int turn_gap;
        exp_q.delete();
        exp_q.push_back(1'b1);
        for (int i = 0; i < 3 + IC; i++) exp_q.push_back(1'b0);
        expv = pack_exp();
        clear_mon();
        tgt_word = word;
        send(2'd1, '0, 1'b0);
        wait_idle();
        turn_gap = (rise_c.size() > 4 + IC) ? rise_c[4 + IC] - rise_c[3 + IC] : -1;
        for (int i = 1; i < rise_c.size(); i++)
            if (i != 4 + IC && rise_c[i] - rise_c[i-1] != 2 * CD) bad_gap++;
        checks++;
        if (n_fall != 4 + IC + RW) begin
            errors++;
            $display("FAIL regout_pulses: got %0d required %0d", n_fall, 4 + IC + RW);
        end
        checks++;
        if (obs_bits[4+IC-1:0] !== expv[4+IC-1:0]) begin
            errors++;
            $display("FAIL regout_bits: got %h required %h", obs_bits[4+IC-1:0], expv[4+IC-1:0]);
        end
        checks++;
        if (obs_dirs !== ones(4 + IC)) begin
            errors++;
            $display("FAIL regout_dir: got %h required %h", obs_dirs, ones(4 + IC));
        end
        checks++;
        if (turn_gap != 4 * CD || bad_gap != 0) begin
            errors++;
            $display("FAIL regout_timing: turn_gap=%0d bad_periods=%0d required %0d 0", turn_gap, bad_gap, 4 * CD);
        end
        checks++;
        if (dv_cnt != 1 || dv_val !== word || dout !== word) begin
            errors++;
            $display("FAIL regout_data: strobes=%0d strobe_val=%h dout=%h required 1 %h", dv_cnt, dv_val, dout, word);
        end
        checks++;
        if ({PGCx, PGDx_out, PGDx_dir} !== 3'b000 || mclr_chg != 0) begin
            errors++;
            $display("FAIL regout_done_pins: got %b mclr_changes=%0d required 000 0", {PGCx, PGDx_out, PGDx_dir}, mclr_chg);
        end
    endtask

    task automatic test_raw(input logic [KW-1:0] key);
        logic [63:0] expv;
        int bad_gap = 0;
        exp_q.delete();
        for (int i = KW - 1; i >= 0; i--) exp_q.push_back(key[i]);
        expv = pack_exp();
        clear_mon();
        send(2'd2, key, 1'b0);
        wait_idle();
        for (int i = 1; i < rise_c.size(); i++) if (rise_c[i] - rise_c[i-1] != 2 * CD) bad_gap++;
        checks++;
        if (n_fall != KW || bad_gap != 0) begin
            errors++;
            $display("FAIL raw_pulses: got %0d bad_periods=%0d required %0d 0", n_fall, bad_gap, KW);
        end
        checks++;
        if (obs_bits !== expv) begin
            errors++;
            $display("FAIL raw_bits: got %h required %h", obs_bits, expv);
        end
        checks++;
        if (obs_dirs !== ones(KW) || dv_cnt != 0 || mclr_chg != 0) begin
            errors++;
            $display("FAIL raw_side: dir=%h dvalid=%0d mclr_changes=%0d required %h 0 0", obs_dirs, dv_cnt, mclr_chg, ones(KW));
        end
    endtask

    task automatic test_mclr(input logic level);
        clear_mon();
        send(2'd3, {{(KW-1){1'b0}}, level}, 1'b0);
        checks++;
        if (MCLRn !== level) begin
            errors++;
            $display("FAIL mclr_level: MCLRn=%b required %b", MCLRn, level);
        end
        wait_idle();
        checks++;
        if (rise_c.size() != 0 || PGCx !== 1'b0 || MCLRn !== level) begin
            errors++;
            $display("FAIL mclr_quiet: pgc_pulses=%0d PGCx=%b MCLRn=%b required 0 0 %b", rise_c.size(), PGCx, MCLRn, level);
        end
    endtask

    task automatic test_back_to_back(input logic [KW-1:0] data, input logic [RW-1:0] word);
        int a1;
        int a2;
        int gap;
        clear_mon();
        tgt_word = word;
        send(2'd0, data, 1'b1);
        a1 = acc_c;
        send(2'd1, '0, 1'b0);
        a2 = acc_c;
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ready_drop: cmd_ready=%b required 0", cmd_ready);
        end
        wait_idle();
        gap = (rise_c.size() > 4 + PW) ? rise_c[4 + PW] - rise_c[3 + PW] : -1;
        checks++;
        if (a2 - a1 != 2 * CD * (4 + PW) + 2) begin
            errors++;
            $display("FAIL b2b_accept: spacing=%0d required %0d", a2 - a1, 2 * CD * (4 + PW) + 2);
        end
        checks++;
        if (gap != 2 * CD + 2) begin
            errors++;
            $display("FAIL b2b_gap: rise_gap=%0d required %0d", gap, 2 * CD + 2);
        end
        checks++;
        if (n_fall != 8 + PW + IC + RW || dv_cnt != 1 || dv_val !== word) begin
            errors++;
            $display("FAIL b2b_result: pulses=%0d strobes=%0d val=%h required %0d 1 %h",
                     n_fall, dv_cnt, dv_val, 8 + PW + IC + RW, word);
        end
    endtask

    task automatic test_reset_mid(input logic [KW-1:0] data);
        int n = 0;
        test_mclr(1'b1);
        clear_mon();
        send(2'd0, data, 1'b0);
        while (rise_c.size() < 14 && n < 500) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (rise_c.size() < 14) begin
            errors++;
            $display("FAIL rstmid_reach: pulses=%0d required 14", rise_c.size());
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({PGCx, PGDx_out, PGDx_dir, MCLRn, cmd_ready, dvalid} !== 6'b000000 || dout !== '0) begin
            errors++;
            $display("FAIL rstmid_pins: got %b dout=%h required 000000 / 0",
                     {PGCx, PGDx_out, PGDx_dir, MCLRn, cmd_ready, dvalid}, dout);
        end
        repeat (2) begin
            @(negedge clk); #1;
        end
        rst = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_ready_early: cmd_ready=%b required 0", cmd_ready);
        end
        @(negedge clk); #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_ready: cmd_ready=%b required 1", cmd_ready);
        end
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if (rise_c.size() != 14 || dv_cnt != 0 || MCLRn !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_dropped: pulses=%0d strobes=%0d MCLRn=%b required 14 0 0", rise_c.size(), dv_cnt, MCLRn);
        end
    endtask

    initial begin
        test_reset();
        test_six(32'h0012_3456);
        test_regout(16'hA5C3);
        test_raw(32'h4D43_4851);
        test_mclr(1'b1);
        for (int k = 0; k < 3; k++) begin
            test_six($urandom);
            test_regout(16'($urandom_range(1, 65535)));
            test_raw($urandom);
        end
        test_back_to_back($urandom, 16'($urandom_range(1, 65535)));
        test_mclr(1'b0);
        test_reset_mid($urandom);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
